// File: rtl/seq_compare_pkg.sv
// Shared definitions for the iterative comparator: mode codes, FSM states
// and the mode-to-result mapping used when a compare terminates.
package seq_compare_pkg;

  localparam int DATASIZE = 32;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LT  = 3'd2;
  localparam logic [2:0] CMP_GE  = 3'd3;
  localparam logic [2:0] CMP_LTU = 3'd4;
  localparam logic [2:0] CMP_GEU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic mode_is_signed(input logic [2:0] m);
    return (m == CMP_LT) || (m == CMP_GE);
  endfunction

  function automatic logic mode_is_reserved(input logic [2:0] m);
    return m > CMP_GEU;
  endfunction

  // Reserved codes yield 0; the caller raises illegal separately.
  function automatic logic mode_result(input logic [2:0] m, input logic eq, input logic lt);
    logic r;
    r = 1'b0;
    case (m)
      CMP_EQ:           r = eq;
      CMP_NE:           r = ~eq;
      CMP_LT, CMP_LTU:  r = lt;
      CMP_GE, CMP_GEU:  r = ~lt;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_compare_if.sv
// Request/response bundle between the register-read stage (master) and the
// comparator (slave).
interface seq_compare_if
  import seq_compare_pkg::*;
#(
  parameter int DATA_W = DATASIZE
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [2:0]        mode;

  logic              out_valid;
  logic              out_ready;
  logic              out;
  logic              eq_flag;
  logic              lt_flag;
  logic              illegal;

  modport master (
    output in_valid, in1, in2, mode, out_ready,
    input  in_ready, out_valid, out, eq_flag, lt_flag, illegal
  );

  modport slave (
    input  in_valid, in1, in2, mode, out_ready,
    output in_ready, out_valid, out, eq_flag, lt_flag, illegal
  );

  modport monitor (
    input in_valid, in1, in2, mode, out_ready,
    input in_ready, out_valid, out, eq_flag, lt_flag, illegal
  );

endinterface

// File: rtl/seq_compare_chunk_cmp.sv
// Combinational equal / unsigned less-than for one CHUNK_W slice.
module chunk_cmp #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  output logic               eq,
  output logic               lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_compare.sv
// Iterative multi-mode comparator: walks operands MSB chunk first, stopping at
// the first differing chunk, and holds the result until the consumer takes it.
module seq_compare
  import seq_compare_pkg::*;
#(
  parameter int DATA_W  = DATASIZE,
  parameter int CHUNK_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort,
  seq_compare_if.slave bus
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(NCHUNK - 1);
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [2:0]         mode_q, mode_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_q, out_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;
  logic               illegal_q, illegal_d;

  logic [CHUNK_W-1:0] a_chunk [NCHUNK];
  logic [CHUNK_W-1:0] b_chunk [NCHUNK];
  logic [CHUNK_W-1:0] a_sel;
  logic [CHUNK_W-1:0] b_sel;
  logic               chunk_eq;
  logic               chunk_lt;

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_chunk[gi] = a_q[gi*CHUNK_W +: CHUNK_W];
      assign b_chunk[gi] = b_q[gi*CHUNK_W +: CHUNK_W];
    end
  endgenerate

  // Explicit compare-and-select keeps the mux clean for any NCHUNK.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sel = a_chunk[i];
        b_sel = b_chunk[i];
      end
    end
  end

  chunk_cmp #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_cmp (
    .a  (a_sel),
    .b  (b_sel),
    .eq (chunk_eq),
    .lt (chunk_lt)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    out_d     = out_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    illegal_d = illegal_q;

    if (abort) begin
      // In IDLE abort only blocks acceptance; elsewhere it flushes the op.
      if (state_q != ST_IDLE) begin
        state_d   = ST_IDLE;
        idx_d     = IDX_TOP;
        out_d     = 1'b0;
        eq_d      = 1'b0;
        lt_d      = 1'b0;
        illegal_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            // Flipping the sign bits makes unsigned chunk order equal signed order.
            a_d     = mode_is_signed(bus.mode) ? (bus.in1 ^ MSB_MASK) : bus.in1;
            b_d     = mode_is_signed(bus.mode) ? (bus.in2 ^ MSB_MASK) : bus.in2;
            mode_d  = bus.mode;
            idx_d   = IDX_TOP;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!chunk_eq || (idx_q == '0)) begin
            eq_d      = chunk_eq;
            lt_d      = chunk_lt;
            illegal_d = mode_is_reserved(mode_q);
            out_d     = mode_result(mode_q, chunk_eq, chunk_lt);
            state_d   = ST_DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
            idx_d   = IDX_TOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = IDX_TOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= CMP_EQ;
      idx_q     <= IDX_TOP;
      out_q     <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = out_q;
  assign bus.eq_flag   = eq_q;
  assign bus.lt_flag   = lt_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_seq_compare.sv
// Randomised bench for seq_compare: directed corner cases plus random ops,
// each checked against a whole-word arithmetic model of result and latency.
module tb_seq_compare;
  import seq_compare_pkg::*;

  localparam int DATA_W  = 32;
  localparam int CHUNK_W = 8;
  localparam int NCHUNK  = DATA_W / CHUNK_W;
  localparam int TIMEOUT = 20;

  logic clk;
  logic rst;
  logic abort;
  int   tests_run;
  int   tests_failed;

  seq_compare_if #(.DATA_W(DATA_W)) bus ();

  seq_compare #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .abort (abort),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Chunks examined = chunks from the top down to the one holding the highest differing bit.
  function automatic int model_k(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a ^ b;
    if (diff == 0) return NCHUNK;
    for (int i = DATA_W - 1; i >= 0; i--)
      if (diff[i]) return NCHUNK - (i / CHUNK_W);
    return NCHUNK;
  endfunction

  function automatic logic model_lt(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    if (m == 3'd2 || m == 3'd3) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  function automatic logic model_out(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    case (m)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) < $signed(b);
      3'd3: return $signed(a) >= $signed(b);
      3'd4: return a < b;
      3'd5: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Called just after a rising edge with the DUT in IDLE; returns just after the edge that re-enters IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m, input int hold);
    int   cyc;
    logic snap_out;
    bus.in1       = a;
    bus.in2       = b;
    bus.mode      = m;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    $display("[TB] op mode=%0d in1=%08h in2=%08h k=%0d out=%0b eq=%0b lt=%0b ill=%0b",
             m, a, b, cyc, bus.out, bus.eq_flag, bus.lt_flag, bus.illegal);
    check("latency", 32'(cyc), 32'(model_k(a, b)));
    check("out", 32'(bus.out), 32'(model_out(a, b, m)));
    check("eq_flag", 32'(bus.eq_flag), 32'(a == b));
    check("lt_flag", 32'(bus.lt_flag), 32'(model_lt(a, b, m)));
    check("illegal", 32'(bus.illegal), 32'(m > 3'd5));
    check("in_ready_done", 32'(bus.in_ready), 32'd0);
    snap_out = bus.out;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in1      = $urandom;
      bus.in2      = $urandom;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_stable", 32'(bus.out), 32'(snap_out));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out"}, 32'(bus.out), 32'd0);
    check({tag, "_eq"}, 32'(bus.eq_flag), 32'd0);
    check({tag, "_lt"}, 32'(bus.lt_flag), 32'd0);
    check({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  m;
    int          pos, seen;
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.mode      = 3'd0;
    bus.out_ready = 1'b0;
    #12;
    check_reset_outputs("por");
    #4 rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'hDEADBEEF, 32'hDEADBEEF, 3'd0, 0);

    // Asynchronous reset in the second BUSY cycle, away from any edge.
    bus.in1 = 32'h00000000; bus.in2 = 32'h00000001; bus.mode = 3'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    $display("[TB] reset asserted mid-BUSY");

    run_op(32'hFFFFFFFF, 32'h00000001, 3'd2, 0);
    run_op(32'hFFFFFFFF, 32'h00000001, 3'd4, 0);
    run_op(32'h12345600, 32'h123456FF, 3'd5, 5);
    run_op(32'h80000000, 32'h7FFFFFFF, 3'd3, 2);

    // abort in the second BUSY cycle must drop the op without a result.
    bus.in1 = 32'hCAFEF00D; bus.in2 = 32'hCAFEF00D; bus.mode = 3'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    $display("[TB] abort issued in second BUSY cycle");
    run_op(32'h11111111, 32'h22222222, 3'd6, 0);

    // abort in IDLE blocks acceptance.
    bus.in1 = 32'h1; bus.in2 = 32'h2; bus.mode = 3'd4; bus.in_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check("idle_abort_in_ready", 32'(bus.in_ready), 32'd1);
    $display("[TB] abort in IDLE with in_valid");

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      b = a;
      pos = $urandom_range(0, NCHUNK);
      if (pos < NCHUNK) b[pos*CHUNK_W +: CHUNK_W] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b[DATA_W-1] = ~b[DATA_W-1];
      if ($urandom_range(0, 5) == 0) b = $urandom;
      m = 3'($urandom_range(0, 7));
      run_op(a, b, m, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
